// File: rtl/mem_access_arbiter_pkg.sv
// Shared types for the memory access arbiter: access/mask encodings, FSM states,
// the memory request section and the LS legality decode.
package mem_access_arbiter_pkg;

    typedef enum logic [1:0] {
        me_rd = 2'd0,
        me_wr = 2'd1,
        me_x  = 2'd2
    } ME_AccessType;

    typedef enum logic [2:0] {
        mt_x  = 3'd0,
        mt_b  = 3'd1,
        mt_h  = 3'd2,
        mt_w  = 3'd3,
        mt_bu = 3'd5,
        mt_hu = 3'd6
    } ME_MaskType;

    typedef enum logic [1:0] {
        arb_idle   = 2'd0,
        arb_check  = 2'd1,
        arb_access = 2'd2,
        arb_resp   = 2'd3
    } MemArbStateType;

    // Request half of a MemSections transaction (address travels separately).
    typedef struct packed {
        logic        valid;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } MemReqSection;

    function automatic logic ls_illegal(input logic [1:0] req, input logic [2:0] mask,
                                        input logic [1:0] a);
        logic ill;
        ill = 1'b0;
        if (req != me_rd && req != me_wr) ill = 1'b1;
        case (mask)
            mt_b, mt_bu: ;
            mt_h, mt_hu: if (a[0]) ill = 1'b1;
            mt_w:        if (a != 2'b00) ill = 1'b1;
            default:     ill = 1'b1;
        endcase
        if (req == me_wr && (mask == mt_bu || mask == mt_hu)) ill = 1'b1;
        return ill;
    endfunction

endpackage

// File: rtl/mem_access_arbiter_lane_align.sv
// Byte-lane alignment: store byte enables / lane replication and load
// shift with sign or zero extension.
module mem_lane_align
    import mem_access_arbiter_pkg::*;
(
    input  logic [2:0]  i_mask,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);
    logic [31:0] w_shifted;

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        case (i_mask)
            mt_b, mt_bu: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            mt_h, mt_hu: begin
                o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

    always_comb begin
        case (i_mask)
            mt_b:    o_rdata = {{24{w_shifted[7]}}, w_shifted[7:0]};
            mt_bu:   o_rdata = {24'd0, w_shifted[7:0]};
            mt_h:    o_rdata = {{16{w_shifted[15]}}, w_shifted[15:0]};
            mt_hu:   o_rdata = {16'd0, w_shifted[15:0]};
            default: o_rdata = w_shifted;
        endcase
    end
endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter sharing one word memory between instruction fetch and
// load/store, with alignment, legality checks and a memory timeout.
module mem_access_arbiter
    import mem_access_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_if_valid,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_ack,
    output logic              o_if_err,
    output logic [31:0]       o_if_rdata,
    input  logic              i_ls_valid,
    input  logic [1:0]        i_ls_req,
    input  logic [2:0]        i_ls_mask,
    input  logic [ADDR_W-1:0] i_ls_addr,
    input  logic [31:0]       i_ls_wdata,
    output logic              o_ls_ack,
    output logic              o_ls_err,
    output logic [31:0]       o_ls_rdata,
    output logic              o_mem_valid,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [3:0]        o_mem_be,
    output logic [31:0]       o_mem_wdata,
    input  logic              i_mem_done,
    input  logic [31:0]       i_mem_rdata
);
    localparam int CNT_W = $clog2(TIMEOUT);

    MemArbStateType    r_state;
    logic              r_grant_ls_last, r_is_ls, r_we, r_err;
    logic [2:0]        r_mask;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata, r_rdata;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_pick_ls, w_illegal, w_acc, w_resp;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata, w_rdata_ext;
    MemReqSection      w_req;

    // Legality is decoded on the arbitrated request as it leaves IDLE, so the
    // memory request is already registered in the following cycle.
    assign w_pick_ls = i_ls_valid && (!i_if_valid || !r_grant_ls_last);
    assign w_illegal = w_pick_ls ? ls_illegal(i_ls_req, i_ls_mask, i_ls_addr[1:0])
                                 : (i_if_addr[1:0] != 2'b00);

    mem_lane_align u_align (
        .i_mask    (r_mask),
        .i_addr_lo (r_addr[1:0]),
        .i_wdata   (r_wdata),
        .i_rdata   (i_mem_rdata),
        .o_be      (w_be),
        .o_wdata   (w_wdata),
        .o_rdata   (w_rdata_ext)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= arb_idle;
            r_grant_ls_last <= 1'b0;
            r_is_ls         <= 1'b0;
            r_we            <= 1'b0;
            r_err           <= 1'b0;
            r_mask          <= '0;
            r_addr          <= '0;
            r_wdata         <= '0;
            r_rdata         <= '0;
            r_cnt           <= '0;
        end else begin
            case (r_state)
                arb_idle: if (i_if_valid || i_ls_valid) begin
                    r_is_ls         <= w_pick_ls;
                    r_grant_ls_last <= w_pick_ls;
                    r_we            <= w_pick_ls && (i_ls_req == me_wr);
                    r_mask          <= w_pick_ls ? i_ls_mask : mt_w;
                    r_addr          <= w_pick_ls ? i_ls_addr : i_if_addr;
                    r_wdata         <= i_ls_wdata;
                    r_cnt           <= '0;
                    r_rdata         <= '0;
                    r_err           <= w_illegal;
                    r_state         <= w_illegal ? arb_resp : arb_access;
                end
                arb_access: begin
                    // A completion in the last allowed cycle beats the timeout.
                    if (i_mem_done) begin
                        r_rdata <= r_we ? 32'd0 : w_rdata_ext;
                        r_state <= arb_resp;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_state <= arb_resp;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                arb_resp: r_state <= arb_idle;
                default:  r_state <= arb_idle;
            endcase
        end
    end

    assign w_acc  = (r_state == arb_access);
    assign w_resp = (r_state == arb_resp);

    assign w_req.valid = w_acc;
    assign w_req.we    = w_acc && r_we;
    assign w_req.be    = w_acc ? (r_we ? w_be : 4'b1111) : 4'b0000;
    assign w_req.wdata = (w_acc && r_we) ? w_wdata : 32'd0;

    assign o_mem_valid = w_req.valid;
    assign o_mem_we    = w_req.we;
    assign o_mem_be    = w_req.be;
    assign o_mem_wdata = w_req.wdata;
    assign o_mem_addr  = w_acc ? {r_addr[ADDR_W-1:2], 2'b00} : '0;

    assign o_if_ack   = w_resp && !r_is_ls;
    assign o_if_err   = o_if_ack && r_err;
    assign o_if_rdata = o_if_ack ? r_rdata : 32'd0;
    assign o_ls_ack   = w_resp && r_is_ls;
    assign o_ls_err   = o_ls_ack && r_err;
    assign o_ls_rdata = o_ls_ack ? r_rdata : 32'd0;
endmodule
